// File: rtl/ntt_sdf_stage_pkg.sv
// Shared types and modular add/subtract helpers for the SDF NTT stage.
package ntt_pkg;

    // Widest data path the helper functions handle.
    localparam int unsigned NTT_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        BFLY,
        DRAIN
    } sdf_state_t;

    function automatic logic [NTT_MAX_W-1:0] width_mask(input int unsigned w);
        return (w >= NTT_MAX_W) ? {NTT_MAX_W{1'b1}} : ~({NTT_MAX_W{1'b1}} << w);
    endfunction

    // (a + b) mod q for a, b < q; one conditional subtract.
    function automatic logic [NTT_MAX_W-1:0] mod_add(
        input logic [NTT_MAX_W-1:0] a,
        input logic [NTT_MAX_W-1:0] b,
        input int unsigned          w,
        input logic [NTT_MAX_W-1:0] q
    );
        logic [NTT_MAX_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, q}) begin
            s = s - {1'b0, q};
        end
        return s[NTT_MAX_W-1:0] & width_mask(w);
    endfunction

    // (a - b) mod q for a, b < q; the extra top bit flags a negative result.
    function automatic logic [NTT_MAX_W-1:0] mod_sub(
        input logic [NTT_MAX_W-1:0] a,
        input logic [NTT_MAX_W-1:0] b,
        input int unsigned          w,
        input logic [NTT_MAX_W-1:0] q
    );
        logic [NTT_MAX_W:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[NTT_MAX_W]) begin
            d = d + {1'b0, q};
        end
        return d[NTT_MAX_W-1:0] & width_mask(w);
    endfunction

endpackage

// File: rtl/ntt_sdf_stage_if.sv
// Sample stream into and out of one SDF NTT stage (no output backpressure).
interface ntt_sdf_stage_if #(
    parameter int unsigned W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic [W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/ntt_sdf_stage_mod_mul_pipe.sv
// Pipelined a*b mod MODULUS; the valid bit travels with the data, MUL_LAT cycles end to end.
module mod_mul_pipe #(
    parameter int unsigned W       = 32,
    parameter int unsigned MODULUS = 7681,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         v_in,
    output logic [W-1:0] p,
    output logic         v_out,
    output logic         pending
);
    localparam int unsigned PW = 2 * W;

    logic [PW-1:0] full_prod;
    assign full_prod = PW'(a) * PW'(b);

    generate
        if (MUL_LAT == 1) begin : g_single
            logic [W-1:0] p_r;
            logic         v_r;

            // Multiply and reduce in a single registered step
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    p_r <= '0;
                    v_r <= 1'b0;
                end else begin
                    p_r <= W'(full_prod % PW'(MODULUS));
                    v_r <= v_in;
                end
            end

            assign p       = p_r;
            assign v_out   = v_r;
            assign pending = v_r;
        end else begin : g_multi
            logic [PW-1:0]      prod_r;
            logic               prod_v;
            logic [W-1:0]       red_r [MUL_LAT-1];
            logic [MUL_LAT-2:0] red_v;

            // Product register, then reduction register, then plain delay stages
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    prod_r <= '0;
                    prod_v <= 1'b0;
                    red_v  <= '0;
                    for (int unsigned i = 0; i < MUL_LAT - 1; i++) begin
                        red_r[i] <= '0;
                    end
                end else begin
                    prod_r   <= full_prod;
                    prod_v   <= v_in;
                    red_r[0] <= W'(prod_r % PW'(MODULUS));
                    red_v[0] <= prod_v;
                    for (int unsigned i = 1; i < MUL_LAT - 1; i++) begin
                        red_r[i] <= red_r[i-1];
                        red_v[i] <= red_v[i-1];
                    end
                end
            end

            assign p       = red_r[MUL_LAT-2];
            assign v_out   = red_v[MUL_LAT-2];
            assign pending = prod_v | (|red_v);
        end
    endgenerate

endmodule

// File: rtl/ntt_sdf_stage.sv
// Radix-2 DIF single-path delay-feedback NTT stage with forward/inverse twiddle banks.
module ntt_sdf_stage
    import ntt_pkg::*;
#(
    parameter int unsigned W       = 32,
    parameter int unsigned MODULUS = 7681,
    parameter int unsigned HALF_N  = 4,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    ntt_sdf_stage_if.slave            stream,
    input  logic                      inv,
    input  logic                      flush,
    input  logic                      tw_we,
    input  logic                      tw_bank,
    input  logic [$clog2(HALF_N)-1:0] tw_addr,
    input  logic [W-1:0]              tw_data,
    output logic                      busy,
    output logic                      tw_err
);
    localparam int unsigned     AW       = $clog2(HALF_N);
    localparam logic [AW-1:0]   CNT_LAST = AW'(HALF_N - 1);

    sdf_state_t    state, state_n;
    logic [AW-1:0] cnt, cnt_n;
    logic          primed, primed_n;
    logic          bank, bank_n;

    logic [W-1:0]  dly_ram [HALF_N];
    logic [AW-1:0] dly_ptr;
    logic [W-1:0]  dly_rd;

    logic [W-1:0]  tw_ram [2][HALF_N];
    logic [W-1:0]  tw_rd;

    logic          boundary;
    logic          in_ready_c;
    logic          accept;
    logic          push;
    logic [W-1:0]  push_data;
    logic          emit;
    logic [W-1:0]  mul_a;
    logic [W-1:0]  mul_b;
    logic          pipe_busy;
    logic [W-1:0]  mul_p;
    logic          mul_v;

    assign dly_rd     = dly_ram[dly_ptr];
    assign tw_rd      = tw_ram[bank][cnt];
    assign boundary   = (state == FILL) && (cnt == '0) && primed;
    assign in_ready_c = (state != DRAIN) && !(boundary && flush);
    assign accept     = stream.in_valid && in_ready_c;
    assign busy       = (state != IDLE) || pipe_busy;

    assign stream.in_ready  = in_ready_c;
    assign stream.out_valid = mul_v;
    assign stream.out_data  = mul_p;

    // Next state, delay-line push and multiplier issue for this cycle
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        primed_n  = primed;
        bank_n    = bank;
        push      = 1'b0;
        push_data = stream.in_data;
        emit      = 1'b0;
        mul_a     = '0;
        mul_b     = W'(1);
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = FILL;
                    cnt_n   = AW'(1);
                    bank_n  = inv;
                    push    = 1'b1;
                end
            end
            FILL: begin
                // Flush wins at a frame boundary: enter DRAIN without taking a sample
                if (boundary && flush) begin
                    state_n = DRAIN;
                end else if (accept) begin
                    push = 1'b1;
                    if (primed) begin
                        emit  = 1'b1;
                        mul_a = dly_rd;
                        mul_b = tw_rd;
                    end
                    if (boundary) begin
                        bank_n = inv;
                    end
                    cnt_n = cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state_n = BFLY;
                    end
                end
            end
            BFLY: begin
                if (accept) begin
                    emit      = 1'b1;
                    mul_a     = W'(mod_add(NTT_MAX_W'(dly_rd), NTT_MAX_W'(stream.in_data),
                                           W, NTT_MAX_W'(MODULUS)));
                    push      = 1'b1;
                    push_data = W'(mod_sub(NTT_MAX_W'(dly_rd), NTT_MAX_W'(stream.in_data),
                                           W, NTT_MAX_W'(MODULUS)));
                    cnt_n     = cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state_n  = FILL;
                        primed_n = 1'b1;
                    end
                end
            end
            DRAIN: begin
                emit      = 1'b1;
                mul_a     = dly_rd;
                mul_b     = tw_rd;
                push      = 1'b1;
                push_data = '0;
                cnt_n     = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    state_n  = IDLE;
                    primed_n = 1'b0;
                end
            end
        endcase
    end

    // FSM state, frame counter, bank select and delay pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            primed  <= 1'b0;
            bank    <= 1'b0;
            dly_ptr <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            primed <= primed_n;
            bank   <= bank_n;
            if (push) begin
                dly_ptr <= dly_ptr + 1'b1;
            end
        end
    end

    // Dropped twiddle write flag, one cycle after the rejected strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tw_err <= 1'b0;
        end else begin
            tw_err <= tw_we && busy;
        end
    end

    // Feedback delay storage; contents are don't-care until the FSM has filled them
    always_ff @(posedge clk) begin
        if (push) begin
            dly_ram[dly_ptr] <= push_data;
        end
    end

    // Twiddle storage, writable only while the stage is fully idle
    always_ff @(posedge clk) begin
        if (tw_we && !busy) begin
            tw_ram[tw_bank][tw_addr] <= tw_data;
        end
    end

    mod_mul_pipe #(
        .W       (W),
        .MODULUS (MODULUS),
        .MUL_LAT (MUL_LAT)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .a       (mul_a),
        .b       (mul_b),
        .v_in    (emit),
        .p       (mul_p),
        .v_out   (mul_v),
        .pending (pipe_busy)
    );

endmodule
